axi_burst_master: RTL and testbench
===================================

Name: axi_burst_master

Overview:
AXI4 burst master that sits directly upstream of axi_slave and drives its AW/W/B and AR/R channels. It accepts one burst command at a time from a simple valid/ready command port. Write data is streamed in, and read data is streamed out. Completion status is reported as a one-cycle done pulse with a response code.

Parameters:
ADDR_W, 32, address width of cmd_addr, AWADDR, ARADDR
DATA_W, 32, data width; AxSIZE driven as log2(DATA_W/8) (3'b010 at default)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1 = write burst, 0 = read burst
cmd_addr  in  ADDR_W  start address
cmd_len  in  8  beats minus 1 (AxLEN encoding)
cmd_burst  in  2  00 FIXED, 01 INCR, 10 WRAP
wd_data  in  DATA_W  write-data stream payload
wd_valid  in  1  write-data stream valid
wd_ready  out  1  write-data stream ready
rd_data  out  DATA_W  read-data stream payload
rd_valid  out  1  read-data stream valid
rd_last  out  1  final beat of the read burst
rd_ready  in  1  read-data stream ready
done  out  1  one-cycle pulse when the command completes
done_resp  out  2  completion response, valid with done
AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID out, AWREADY in  per AXI4
WDATA/WVALID/WLAST out, WREADY in  per AXI4
BRESP/BVALID in, BREADY out  per AXI4
ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID out, ARREADY in  per AXI4
RDATA/RRESP/RLAST/RVALID in, RREADY out  per AXI4

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high. Reset forces state IDLE.
- Reset values: all VALID/READY outputs, done, rd_last, WLAST, cmd_ready = 0. Address, length, size, burst and done_resp registers = 0.
- While reset is high, cmd_ready = 0. cmd_ready = 1 in IDLE only.
- States: IDLE, CHK, AW, W, B, AR, R, DONE.
- IDLE: on cmd_valid && cmd_ready, latch cmd_*; go to CHK.
- CHK (1 cycle): legality check. Illegal commands are:
  - burst 11
  - FIXED with len > 15
  - WRAP with len not in {1, 3, 7, 15}
  - WRAP with addr not aligned to (len+1)*DATA_W/8
  - Illegal command -> DONE with done_resp = 2'b10 and no bus activity.
  - Legal command -> AW if write, AR if read.
- AW: AWVALID = 1 with the latched fields stable. AWVALID is held until AWREADY is sampled high; then go to W.
  - WVALID is never asserted before the AW handshake completes.
- W: combinational pass-through.
  - WVALID = wd_valid, WDATA = wd_data, wd_ready = WREADY.
  - 8-bit beat counter beat increments on each WVALID && WREADY.
  - WLAST = (beat == len).
  - After the last beat handshake, go to B.
  - wd_ready = 0 in every other state.
- B: BREADY = 1. On BVALID, capture BRESP into done_resp and go to DONE.
- AR: ARVALID = 1, held until ARREADY is sampled high; then go to R.
- R: pass-through.
  - rd_valid = RVALID, rd_data = RDATA, RREADY = rd_ready.
  - rd_last = (beat == len), so the master-side count governs rd_last.
  - Beat counter increments on each RVALID && RREADY.
  - done_resp accumulates the worst RRESP seen, ordered 11 > 10 > 01 > 00.
  - If RLAST != (beat == len) on any accepted beat, done_resp is forced to 2'b10 (sticky).
  - After the accepted beat with beat == len, go to DONE.
- DONE: done = 1 for exactly one cycle, then IDLE. A new command can be accepted the following cycle.
- Latency, minimum, with a slave that is always ready:
  - Write: cmd handshake -> AWVALID 2 cycles later.
  - Read: last R beat -> done the next cycle.
- len = 0: single beat; WLAST and rd_last are high on the first beat.
- Back-pressure: any number of stall cycles on AW/W/B/AR/R is tolerated. VALID and payload stay stable while stalled.
- Reset mid-burst: all VALIDs drop immediately, no done pulse, state IDLE, counters cleared.

Decomposition:
- Package axi_pkg holds:
  - burst encodings BURST_FIXED/INCR/WRAP
  - response codes RESP_OKAY/EXOKAY/SLVERR/DECERR
  - the state enum
  - the resp_worst() function
- One sub-module, axi_burst_check: combinational legality check (addr, len, burst -> legal) used in CHK; unit-testable alone.

Test Plan:
1. Write INCR, addr 0x20, len 7, data 0x200..0x207, slave always ready -> 8 W beats, WLAST only on the 8th beat, AWADDR = 0x20, done with done_resp = 00.
2. Read INCR, addr 0x20, len 7, after test 1 -> rd_data = 0x200..0x207 in order, rd_last on beat 8 only, done with done_resp = 00.
3. WRAP, addr 0x44, len 3 -> rejected in CHK, no AWVALID, done with done_resp = 10. WRAP, addr 0x40, len 3 -> accepted, AWBURST = 10.
4. FIXED write, addr 0x0, len 3, data 0x100..0x103, random WREADY/BVALID stalls -> payload stable during stalls, 4 beats, done with done_resp = 00.
5. Read in which the slave returns RRESP = 10 on beat 2 of 4, and separately RLAST early on beat 3 -> done_resp = 10 in both cases; rd_last is still asserted on beat 4 only.
6. Reset asserted during W beat 2 -> VALIDs drop asynchronously, no done pulse. A subsequent len-0 read completes normally with done_resp = 00.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI encodings, burst-master FSM states and the response-severity
// helper used by axi_burst_master and axi_burst_check.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CHK  = 3'd1,
        ST_AW   = 3'd2,
        ST_W    = 3'd3,
        ST_B    = 3'd4,
        ST_AR   = 3'd5,
        ST_R    = 3'd6,
        ST_DONE = 3'd7
    } state_t;

    // Severity order DECERR > SLVERR > EXOKAY > OKAY matches the numeric encoding.
    function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] worst;
        if (a >= b) begin
            worst = a;
        end else begin
            worst = b;
        end
        return worst;
    endfunction

endpackage

// File: rtl/axi_burst_check.sv
// Combinational legality check of a latched burst command (burst type,
// length and WRAP alignment); legal = 1 when the command may go on the bus.
module axi_burst_check
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        len,
    input  logic [1:0]        burst,
    output logic              legal
);

    localparam int BYTES = DATA_W / 8;

    logic [ADDR_W-1:0] wrap_mask_s;
    logic              wrap_len_ok_s;

    // Decide legality; WRAP needs a power-of-two beat count and a start aligned to the whole window.
    always_comb begin
        wrap_mask_s   = ((ADDR_W'(len) + ADDR_W'(1)) * ADDR_W'(BYTES)) - ADDR_W'(1);
        wrap_len_ok_s = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        case (burst)
            BURST_FIXED: legal = (len <= 8'd15);
            BURST_INCR:  legal = 1'b1;
            BURST_WRAP:  legal = wrap_len_ok_s && ((addr & wrap_mask_s) == '0);
            default:     legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/axi_burst_master.sv
// Single-command AXI4 burst master: latches a command, checks it, runs one
// AW/W/B or AR/R burst with streamed data and pulses done with a response.
module axi_burst_master
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [7:0]        cmd_len,
    input  logic [1:0]        cmd_burst,
    input  logic [DATA_W-1:0] wd_data,
    input  logic              wd_valid,
    output logic              wd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_last,
    input  logic              rd_ready,
    output logic              done,
    output logic [1:0]        done_resp,
    output logic [ADDR_W-1:0] AWADDR,
    output logic [7:0]        AWLEN,
    output logic [2:0]        AWSIZE,
    output logic [1:0]        AWBURST,
    output logic              AWVALID,
    input  logic              AWREADY,
    output logic [DATA_W-1:0] WDATA,
    output logic              WVALID,
    output logic              WLAST,
    input  logic              WREADY,
    input  logic [1:0]        BRESP,
    input  logic              BVALID,
    output logic              BREADY,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [7:0]        ARLEN,
    output logic [2:0]        ARSIZE,
    output logic [1:0]        ARBURST,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RLAST,
    input  logic              RVALID,
    output logic              RREADY
);

    localparam logic [2:0] SIZE_ENC = 3'($clog2(DATA_W / 8));

    state_t            state_r;
    state_t            state_s;
    logic [ADDR_W-1:0] addr_r;
    logic [7:0]        len_r;
    logic [1:0]        burst_r;
    logic [2:0]        size_r;
    logic              write_r;
    logic [7:0]        beat_r;
    logic [1:0]        done_resp_r;
    logic              rlast_err_r;
    logic              legal_s;
    logic              last_beat_s;
    logic              w_hs_s;
    logic              r_hs_s;

    axi_burst_check #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_check (
        .addr  (addr_r),
        .len   (len_r),
        .burst (burst_r),
        .legal (legal_s)
    );

    assign last_beat_s = (beat_r == len_r);
    assign w_hs_s      = (state_r == ST_W) && wd_valid && WREADY;
    assign r_hs_s      = (state_r == ST_R) && RVALID && rd_ready;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode and state-decoded bus/stream outputs.
    always_comb begin
        state_s   = state_r;
        cmd_ready = (state_r == ST_IDLE) && !reset;
        AWVALID   = 1'b0;
        WVALID    = 1'b0;
        WLAST     = 1'b0;
        WDATA     = wd_data;
        wd_ready  = 1'b0;
        BREADY    = 1'b0;
        ARVALID   = 1'b0;
        RREADY    = 1'b0;
        rd_valid  = 1'b0;
        rd_last   = 1'b0;
        rd_data   = RDATA;
        done      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_s = ST_CHK;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CHK: begin
                if (!legal_s) begin
                    state_s = ST_DONE;
                end else if (write_r) begin
                    state_s = ST_AW;
                end else begin
                    state_s = ST_AR;
                end
            end
            ST_AW: begin
                AWVALID = 1'b1;
                if (AWREADY) begin
                    state_s = ST_W;
                end else begin
                    state_s = ST_AW;
                end
            end
            ST_W: begin
                WVALID   = wd_valid;
                wd_ready = WREADY;
                WLAST    = last_beat_s;
                if (w_hs_s && last_beat_s) begin
                    state_s = ST_B;
                end else begin
                    state_s = ST_W;
                end
            end
            ST_B: begin
                BREADY = 1'b1;
                if (BVALID) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_B;
                end
            end
            ST_AR: begin
                ARVALID = 1'b1;
                if (ARREADY) begin
                    state_s = ST_R;
                end else begin
                    state_s = ST_AR;
                end
            end
            ST_R: begin
                rd_valid = RVALID;
                RREADY   = rd_ready;
                rd_last  = last_beat_s;
                if (r_hs_s && last_beat_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_R;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Command latch, beat counter and completion-response accumulation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_r      <= '0;
            len_r       <= 8'd0;
            burst_r     <= 2'b00;
            size_r      <= 3'b000;
            write_r     <= 1'b0;
            beat_r      <= 8'd0;
            done_resp_r <= 2'b00;
            rlast_err_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        addr_r      <= cmd_addr;
                        len_r       <= cmd_len;
                        burst_r     <= cmd_burst;
                        size_r      <= SIZE_ENC;
                        write_r     <= cmd_write;
                        beat_r      <= 8'd0;
                        done_resp_r <= RESP_OKAY;
                        rlast_err_r <= 1'b0;
                    end
                end
                ST_CHK: begin
                    if (!legal_s) begin
                        done_resp_r <= RESP_SLVERR;
                    end
                end
                ST_W: begin
                    if (w_hs_s) begin
                        beat_r <= beat_r + 8'd1;
                    end
                end
                ST_B: begin
                    if (BVALID) begin
                        done_resp_r <= BRESP;
                    end
                end
                ST_R: begin
                    if (r_hs_s) begin
                        beat_r <= beat_r + 8'd1;
                        // A slave whose RLAST disagrees with our beat count poisons the whole burst.
                        if (rlast_err_r || (RLAST != last_beat_s)) begin
                            rlast_err_r <= 1'b1;
                            done_resp_r <= RESP_SLVERR;
                        end else begin
                            done_resp_r <= resp_worst(done_resp_r, RRESP);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign done_resp = done_resp_r;
    assign AWADDR    = addr_r;
    assign AWLEN     = len_r;
    assign AWSIZE    = size_r;
    assign AWBURST   = burst_r;
    assign ARADDR    = addr_r;
    assign ARLEN     = len_r;
    assign ARSIZE    = size_r;
    assign ARBURST   = burst_r;

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master with a small behavioural AXI slave
// (memory, optional random stalls, RRESP/RLAST fault injection).
module tb_axi_burst_master;
    import axi_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = 32'h0;
    logic [7:0]  cmd_len = 8'h0;
    logic [1:0]  cmd_burst = 2'b00;
    logic [31:0] wd_data = 32'h0;
    logic        wd_valid = 1'b0, wd_ready;
    logic [31:0] rd_data;
    logic        rd_valid, rd_last, rd_ready = 1'b0;
    logic        done;
    logic [1:0]  done_resp;
    logic [31:0] AWADDR, ARADDR, WDATA, RDATA = 32'h0;
    logic [7:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [1:0]  AWBURST, ARBURST, BRESP = 2'b00, RRESP = 2'b00;
    logic        AWVALID, AWREADY = 1'b0, WVALID, WLAST, WREADY = 1'b0;
    logic        BVALID = 1'b0, BREADY, ARVALID, ARREADY = 1'b0;
    logic        RLAST = 1'b0, RVALID = 1'b0, RREADY;

    axi_burst_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_burst(cmd_burst),
        .wd_data(wd_data), .wd_valid(wd_valid), .wd_ready(wd_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
        .done(done), .done_resp(done_resp),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WLAST(WLAST), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // slave model state
    logic [31:0] mem [0:255];
    logic        stall = 1'b0;
    int          err_beat = -1, early_beat = -1;
    logic [31:0] aw_a = 32'h0, ar_a = 32'h0;
    logic [7:0]  aw_l = 8'h0, ar_l = 8'h0;
    logic [1:0]  aw_b = 2'b00, ar_b = 2'b00;
    int          wbeat = 0, rbeat = 0, b_wait = 0;
    logic        b_pend = 1'b0, r_act = 1'b0;
    logic [31:0] wd_q [$];

    // handshakes and captures sampled on the falling edge
    logic        s_aw_hs = 1'b0, s_w_hs = 1'b0, s_b_hs = 1'b0, s_ar_hs = 1'b0, s_r_hs = 1'b0, s_wd_hs = 1'b0;
    logic [31:0] cap_awaddr = 32'h0, cap_araddr = 32'h0, cap_wdata = 32'h0;
    logic [7:0]  cap_awlen = 8'h0, cap_arlen = 8'h0;
    logic [1:0]  cap_awburst = 2'b00, cap_arburst = 2'b00;
    logic [2:0]  cap_awsize = 3'b0;

    // monitor counters
    int          cyc = 0, cmd_cyc = 0, first_aw = -1, last_r = 0, done_cyc = 0;
    int          aw_cycles = 0, ar_cycles = 0, w_beats = 0, wlast_cnt = 0, wlast_beat = 0;
    int          rlast_cnt = 0, rlast_beat = 0, done_cnt = 0, unstable = 0;
    logic [1:0]  got_resp = 2'b00;
    logic [31:0] rd_got [$];
    logic        p_aw = 1'b0, p_w = 1'b0, p_r = 1'b0, p_wlast = 1'b0, p_rlast = 1'b0;
    logic [31:0] p_awaddr = 32'h0, p_wdata = 32'h0, p_rdata = 32'h0;

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [7:0] l,
                                              input logic [1:0] b, input int n);
        logic [31:0] sz, base;
        if (b == BURST_FIXED) return a;
        if (b == BURST_INCR) return a + 32'(n * 4);
        sz   = (32'(l) + 32'd1) * 32'd4;
        base = a & ~(sz - 32'd1);
        return base + ((a - base + 32'(n * 4)) % sz);
    endfunction

    function automatic int midx(input logic [31:0] a);
        return int'(a[9:2]);
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            s_aw_hs = 1'b0; s_w_hs = 1'b0; s_b_hs = 1'b0; s_ar_hs = 1'b0; s_r_hs = 1'b0; s_wd_hs = 1'b0;
            p_aw = 1'b0; p_w = 1'b0; p_r = 1'b0;
        end else begin
            s_aw_hs = AWVALID && AWREADY;
            s_w_hs  = WVALID && WREADY;
            s_b_hs  = BVALID && BREADY;
            s_ar_hs = ARVALID && ARREADY;
            s_r_hs  = RVALID && RREADY;
            s_wd_hs = wd_valid && wd_ready;
            cap_awaddr = AWADDR; cap_awlen = AWLEN; cap_awburst = AWBURST; cap_awsize = AWSIZE;
            cap_araddr = ARADDR; cap_arlen = ARLEN; cap_arburst = ARBURST; cap_wdata = WDATA;
            if (cmd_valid && cmd_ready) cmd_cyc = cyc;
            if (AWVALID) begin aw_cycles++; if (first_aw < 0) first_aw = cyc; end
            if (ARVALID) ar_cycles++;
            if (s_w_hs) begin
                w_beats++;
                if (WLAST) begin wlast_cnt++; wlast_beat = w_beats; end
            end
            if (rd_valid && rd_ready) begin
                rd_got.push_back(rd_data);
                last_r = cyc;
                if (rd_last) begin rlast_cnt++; rlast_beat = rd_got.size(); end
            end
            if (done) begin done_cnt++; done_cyc = cyc; got_resp = done_resp; end
            if (p_aw && !(AWVALID && AWADDR == p_awaddr)) unstable++;
            if (p_w && !(WVALID && WDATA == p_wdata && WLAST == p_wlast)) unstable++;
            if (p_r && !(rd_valid && rd_data == p_rdata && rd_last == p_rlast)) unstable++;
            p_aw = AWVALID && !AWREADY; p_awaddr = AWADDR;
            p_w  = WVALID && !WREADY;   p_wdata = WDATA; p_wlast = WLAST;
            p_r  = rd_valid && !rd_ready; p_rdata = rd_data; p_rlast = rd_last;
        end
    end

    always @(posedge clk) begin
        #1;
        if (reset) begin
            b_pend = 1'b0; r_act = 1'b0; wbeat = 0; rbeat = 0; wd_q.delete();
            BVALID = 1'b0; RVALID = 1'b0; wd_valid = 1'b0;
        end else begin
            if (s_aw_hs) begin aw_a = cap_awaddr; aw_l = cap_awlen; aw_b = cap_awburst; wbeat = 0; end
            if (s_w_hs) begin
                mem[midx(beat_addr(aw_a, aw_l, aw_b, wbeat))] = cap_wdata;
                wbeat++;
                if (wbeat == int'(aw_l) + 1) begin
                    b_pend = 1'b1;
                    b_wait = stall ? int'($urandom_range(0, 3)) : 0;
                end
            end
            if (s_b_hs) b_pend = 1'b0;
            if (s_ar_hs) begin ar_a = cap_araddr; ar_l = cap_arlen; ar_b = cap_arburst; r_act = 1'b1; rbeat = 0; end
            if (s_r_hs) begin rbeat++; if (rbeat > int'(ar_l)) r_act = 1'b0; end
            if (s_wd_hs && wd_q.size() > 0) void'(wd_q.pop_front());
            if (b_pend && b_wait > 0) begin b_wait--; BVALID = 1'b0; end
            else BVALID = b_pend;
            if (!(RVALID && !s_r_hs)) RVALID = r_act && (stall ? 1'($urandom_range(0, 1)) : 1'b1);
            if (!(wd_valid && !s_wd_hs)) wd_valid = (wd_q.size() > 0) && (stall ? 1'($urandom_range(0, 1)) : 1'b1);
            wd_data = (wd_q.size() > 0) ? wd_q[0] : 32'h0;
        end
        AWREADY  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        WREADY   = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        ARREADY  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        rd_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        BRESP    = 2'b00;
        RDATA    = mem[midx(beat_addr(ar_a, ar_l, ar_b, rbeat))];
        RRESP    = (rbeat == err_beat) ? 2'b10 : 2'b00;
        RLAST    = (rbeat == int'(ar_l)) || (rbeat == early_beat);
    end

    task automatic clear_mon();
        first_aw = -1; aw_cycles = 0; ar_cycles = 0; w_beats = 0; wlast_cnt = 0; wlast_beat = 0;
        rlast_cnt = 0; rlast_beat = 0; done_cnt = 0; unstable = 0; got_resp = 2'b11; rd_got.delete();
    endtask

    task automatic load_wd(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) wd_q.push_back(base + 32'(i));
    endtask

    task automatic issue(input logic wr, input logic [31:0] a, input logic [7:0] l, input logic [1:0] b);
        int n = 0;
        @(posedge clk); #2;
        cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_burst = b; cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #2;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 400) begin @(negedge clk); #1; n++; end
        check_eq({tag, "_done_seen"}, 64'(done_cnt), 64'd1);
        repeat (2) @(negedge clk);
        #1;
        check_eq({tag, "_single_done"}, 64'(done_cnt), 64'd1);
    endtask

    logic [31:0] ill_a [4] = '{32'h44, 32'h0, 32'h0, 32'h40};
    logic [7:0]  ill_l [4] = '{8'd3, 8'd16, 8'd0, 8'd2};
    logic [1:0]  ill_b [4] = '{BURST_WRAP, BURST_FIXED, 2'b11, BURST_WRAP};
    logic        ill_w [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        repeat (3) @(posedge clk);
        #3;
        check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check_eq("rst_valids", 64'({AWVALID, WVALID, ARVALID, BREADY, RREADY, wd_ready, rd_valid}), 64'd0);
        check_eq("rst_done", 64'({done, rd_last, WLAST}), 64'd0);
        check_eq("rst_regs", 64'({done_resp, AWADDR, AWLEN, AWSIZE, AWBURST}), 64'd0);
        @(posedge clk); #3; reset = 1'b0;
        @(negedge clk); #1;
        check_eq("idle_cmd_ready", 64'(cmd_ready), 64'd1);

        // 1: INCR write
        clear_mon(); load_wd(32'h200, 8);
        issue(1'b1, 32'h20, 8'd7, BURST_INCR);
        wait_done("t1");
        check_eq("t1_awaddr", 64'(cap_awaddr), 64'h20);
        check_eq("t1_awfields", 64'({cap_awlen, cap_awsize, cap_awburst}), 64'({8'd7, 3'b010, 2'b01}));
        check_eq("t1_aw_latency", 64'(first_aw - cmd_cyc), 64'd2);
        check_eq("t1_beats", 64'(w_beats), 64'd8);
        check_eq("t1_wlast", 64'({wlast_cnt[7:0], wlast_beat[7:0]}), 64'h0108);
        check_eq("t1_resp", 64'(got_resp), 64'd0);
        for (int i = 0; i < 8; i++) check_eq($sformatf("t1_mem%0d", i), 64'(mem[8 + i]), 64'(32'h200 + 32'(i)));

        // 2: INCR read back
        clear_mon();
        issue(1'b0, 32'h20, 8'd7, BURST_INCR);
        wait_done("t2");
        check_eq("t2_count", 64'(rd_got.size()), 64'd8);
        for (int i = 0; i < rd_got.size(); i++) check_eq($sformatf("t2_data%0d", i), 64'(rd_got[i]), 64'(32'h200 + 32'(i)));
        check_eq("t2_rlast", 64'({rlast_cnt[7:0], rlast_beat[7:0]}), 64'h0108);
        check_eq("t2_done_latency", 64'(done_cyc - last_r), 64'd1);
        check_eq("t2_resp", 64'(got_resp), 64'd0);

        // 3: illegal commands, then a legal WRAP
        for (int k = 0; k < 4; k++) begin
            clear_mon();
            issue(ill_w[k], ill_a[k], ill_l[k], ill_b[k]);
            wait_done($sformatf("ill%0d", k));
            check_eq($sformatf("ill%0d_resp", k), 64'(got_resp), 64'd2);
            check_eq($sformatf("ill%0d_nobus", k), 64'(aw_cycles + ar_cycles), 64'd0);
        end
        clear_mon(); load_wd(32'h300, 4);
        issue(1'b1, 32'h40, 8'd3, BURST_WRAP);
        wait_done("t3");
        check_eq("t3_awburst", 64'(cap_awburst), 64'd2);
        check_eq("t3_resp", 64'(got_resp), 64'd0);
        check_eq("t3_mem", 64'({mem[16], mem[19]}), 64'({32'h300, 32'h303}));

        // 4: FIXED write with random stalls
        stall = 1'b1;
        clear_mon(); load_wd(32'h100, 4);
        issue(1'b1, 32'h0, 8'd3, BURST_FIXED);
        wait_done("t4");
        check_eq("t4_beats", 64'(w_beats), 64'd4);
        check_eq("t4_wlast", 64'({wlast_cnt[7:0], wlast_beat[7:0]}), 64'h0104);
        check_eq("t4_stable", 64'(unstable), 64'd0);
        check_eq("t4_resp", 64'(got_resp), 64'd0);
        check_eq("t4_mem", 64'(mem[0]), 64'h103);

        // 5a: SLVERR on beat 2 with stalls
        clear_mon(); err_beat = 1;
        issue(1'b0, 32'h20, 8'd3, BURST_INCR);
        wait_done("t5a");
        check_eq("t5a_resp", 64'(got_resp), 64'd2);
        check_eq("t5a_rlast", 64'({rlast_cnt[7:0], rlast_beat[7:0]}), 64'h0104);
        check_eq("t5a_data3", 64'((rd_got.size() == 4) ? rd_got[3] : 32'h0), 64'h203);
        check_eq("t5a_stable", 64'(unstable), 64'd0);
        // 5b: early RLAST on beat 3
        stall = 1'b0; err_beat = -1; early_beat = 2;
        clear_mon();
        issue(1'b0, 32'h20, 8'd3, BURST_INCR);
        wait_done("t5b");
        check_eq("t5b_resp", 64'(got_resp), 64'd2);
        check_eq("t5b_rlast", 64'({rlast_cnt[7:0], rlast_beat[7:0]}), 64'h0104);
        early_beat = -1;

        // 6: reset during W beat 2, then a len-0 read
        clear_mon(); load_wd(32'h500, 4);
        issue(1'b1, 32'h80, 8'd3, BURST_INCR);
        for (int n = 0; n < 100 && w_beats < 1; n++) begin @(negedge clk); #1; end
        check_eq("t6_beat1", 64'(w_beats), 64'd1);
        @(posedge clk); #3;
        check_eq("t6_wvalid_pre", 64'(WVALID), 64'd1);
        reset = 1'b1;
        #1;
        check_eq("t6_drop", 64'({AWVALID, WVALID, wd_ready, BREADY, ARVALID, RREADY, cmd_ready, done}), 64'd0);
        repeat (3) @(posedge clk);
        #3; reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("t6_no_done", 64'(done_cnt), 64'd0);
        check_eq("t6_idle", 64'(cmd_ready), 64'd1);
        clear_mon();
        issue(1'b0, 32'h20, 8'd0, BURST_INCR);
        wait_done("t6r");
        check_eq("t6r_data", 64'((rd_got.size() == 1) ? rd_got[0] : 32'h0), 64'h200);
        check_eq("t6r_rlast", 64'({rlast_cnt[7:0], rlast_beat[7:0]}), 64'h0101);
        check_eq("t6r_resp", 64'(got_resp), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
